// File: rtl/l2_bus_receiver.sv
// L2 request receiver: merges L1 and snoop requests into one decoded FIFO; 1-cycle enqueue-to-head latency.
// Backpressure: readiness comes from registered occupancy only, and snoop wins the last free slot.
module l2_bus_receiver #(
  parameter int ADDR_WIDTH  = 32,
  parameter int OFFSET_BITS = 6,
  parameter int INDEX_BITS  = 14,
  parameter int DEPTH       = 4,
  localparam int TAG_BITS   = ADDR_WIDTH - INDEX_BITS - OFFSET_BITS,
  localparam int PTR_W      = $clog2(DEPTH),
  localparam int CNT_W      = PTR_W + 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [ADDR_WIDTH-1:0]  l1_addr,
  input  logic [7:0]             l1_op,
  input  logic                   l1_valid,
  output logic                   l1_ready,
  input  logic [ADDR_WIDTH-1:0]  shared_addr,
  input  logic [7:0]             shared_op,
  input  logic                   shared_valid,
  output logic                   shared_ready,
  output logic                   req_valid,
  input  logic                   req_ready,
  output logic [2:0]             req_kind,
  output logic [TAG_BITS-1:0]    req_tag,
  output logic [INDEX_BITS-1:0]  req_index,
  output logic [OFFSET_BITS-1:0] req_offset,
  output logic                   req_is_snoop,
  output logic [CNT_W-1:0]       fifo_count,
  output logic                   illegal_op,
  output logic [7:0]             err_count
);

  localparam logic [7:0] OP_I = 8'h49;
  localparam logic [7:0] OP_R = 8'h52;
  localparam logic [7:0] OP_W = 8'h57;
  localparam logic [7:0] OP_M = 8'h4D;

  localparam logic [2:0] K_L1_READ  = 3'd0;
  localparam logic [2:0] K_L1_WRITE = 3'd1;
  localparam logic [2:0] K_SNP_INV  = 3'd2;
  localparam logic [2:0] K_SNP_RD   = 3'd3;
  localparam logic [2:0] K_SNP_WR   = 3'd4;
  localparam logic [2:0] K_SNP_RWIM = 3'd5;

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef struct packed {
    logic [2:0]            kind;
    logic [ADDR_WIDTH-1:0] addr;
  } entry_t;

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] l1_slot;
  logic [CNT_W-1:0] free_slots;
  logic             rdy_en;

  logic       l1_legal, snp_legal;
  logic [2:0] l1_kind, snp_kind;
  logic       l1_acc, snp_acc, l1_enq, snp_enq, deq;
  logic [1:0] n_enq, n_ill;
  logic [8:0] err_sum;
  entry_t     head;

  // rdy_en holds readiness low for the first cycle after reset is released.
  assign free_slots   = DEPTH_C - fifo_count;
  assign shared_ready = rdy_en && !reset && (fifo_count < DEPTH_C);
  assign l1_ready     = rdy_en && !reset &&
                        ((free_slots >= CNT_W'(2)) ||
                         ((free_slots == CNT_W'(1)) && !shared_valid));

  always_comb begin
    l1_legal  = 1'b1;
    l1_kind   = K_L1_READ;
    snp_legal = 1'b1;
    snp_kind  = K_SNP_INV;
    case (l1_op)
      OP_R:    l1_kind = K_L1_READ;
      OP_W:    l1_kind = K_L1_WRITE;
      default: l1_legal = 1'b0;
    endcase
    case (shared_op)
      OP_I:    snp_kind = K_SNP_INV;
      OP_R:    snp_kind = K_SNP_RD;
      OP_W:    snp_kind = K_SNP_WR;
      OP_M:    snp_kind = K_SNP_RWIM;
      default: snp_legal = 1'b0;
    endcase
  end

  assign snp_acc = shared_valid && shared_ready;
  assign l1_acc  = l1_valid && l1_ready;
  assign snp_enq = snp_acc && snp_legal;
  assign l1_enq  = l1_acc && l1_legal;
  assign deq     = req_valid && req_ready;
  assign n_enq   = {1'b0, snp_enq} + {1'b0, l1_enq};
  assign n_ill   = {1'b0, snp_acc && !snp_legal} + {1'b0, l1_acc && !l1_legal};
  assign err_sum = {1'b0, err_count} + 9'(n_ill);
  // Snoop takes the first free slot; L1 lands behind it when both enqueue.
  assign l1_slot = snp_enq ? wr_ptr + PTR_W'(1) : wr_ptr;

  always_ff @(posedge clk) begin
    if (snp_enq) mem[wr_ptr]  <= '{kind: snp_kind, addr: shared_addr};
    if (l1_enq)  mem[l1_slot] <= '{kind: l1_kind, addr: l1_addr};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      err_count  <= '0;
      illegal_op <= 1'b0;
      rdy_en     <= 1'b0;
    end else begin
      wr_ptr     <= wr_ptr + PTR_W'(n_enq);
      rd_ptr     <= rd_ptr + PTR_W'(deq);
      fifo_count <= fifo_count + CNT_W'(n_enq) - CNT_W'(deq);
      err_count  <= (err_sum > 9'd255) ? 8'hFF : err_sum[7:0];
      illegal_op <= (n_ill != 2'd0);
      rdy_en     <= 1'b1;
    end
  end

  assign head         = mem[rd_ptr];
  assign req_valid    = (fifo_count != '0);
  assign req_kind     = head.kind;
  assign req_tag      = head.addr[ADDR_WIDTH-1 -: TAG_BITS];
  assign req_index    = head.addr[OFFSET_BITS +: INDEX_BITS];
  assign req_offset   = head.addr[OFFSET_BITS-1:0];
  assign req_is_snoop = (head.kind >= K_SNP_INV);

endmodule

// File: tb/tb_l2_bus_receiver.sv
// Directed + randomized bench for l2_bus_receiver with a queue-based reference model.
module tb_l2_bus_receiver;
  localparam int AW = 32;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] l1_addr = '0;
  logic [7:0]  l1_op = '0;
  logic        l1_valid = 1'b0;
  logic        l1_ready;
  logic [31:0] shared_addr = '0;
  logic [7:0]  shared_op = '0;
  logic        shared_valid = 1'b0;
  logic        shared_ready;
  logic        req_valid;
  logic        req_ready = 1'b0;
  logic [2:0]  req_kind;
  logic [11:0] req_tag;
  logic [13:0] req_index;
  logic [5:0]  req_offset;
  logic        req_is_snoop;
  logic [2:0]  fifo_count;
  logic        illegal_op;
  logic [7:0]  err_count;

  l2_bus_receiver dut (
    .clk(clk), .reset(reset),
    .l1_addr(l1_addr), .l1_op(l1_op), .l1_valid(l1_valid), .l1_ready(l1_ready),
    .shared_addr(shared_addr), .shared_op(shared_op), .shared_valid(shared_valid),
    .shared_ready(shared_ready),
    .req_valid(req_valid), .req_ready(req_ready), .req_kind(req_kind),
    .req_tag(req_tag), .req_index(req_index), .req_offset(req_offset),
    .req_is_snoop(req_is_snoop), .fifo_count(fifo_count),
    .illegal_op(illegal_op), .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          kind;
    logic [31:0] addr;
  } ent_t;

  ent_t q[$];
  int   m_err = 0;
  bit   m_ill = 0;
  bit   m_rdy = 0;
  int   errors = 0;
  int   checks = 0;
  logic [7:0] ops [5] = '{8'h49, 8'h52, 8'h57, 8'h4D, 8'h58};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Opcode meaning straight from the kind table; -1 marks an illegal opcode.
  function automatic int kind_of(input bit snp, input logic [7:0] op);
    if (!snp) begin
      if (op == 8'h52) return 0;
      if (op == 8'h57) return 1;
      return -1;
    end
    case (op)
      8'h49:   return 2;
      8'h52:   return 3;
      8'h57:   return 4;
      8'h4D:   return 5;
      default: return -1;
    endcase
  endfunction

  // One clock: drive, check current outputs against the model, then advance the model.
  task automatic cycle(input bit sv, input logic [7:0] sop, input logic [31:0] sa,
                       input bit lv, input logic [7:0] lop, input logic [31:0] la,
                       input bit rr);
    int  free, k, nill;
    bit  exp_sr, exp_lr, deq;
    shared_valid = sv; shared_op = sop; shared_addr = sa;
    l1_valid = lv; l1_op = lop; l1_addr = la; req_ready = rr;
    #1;
    free   = DEPTH - q.size();
    exp_sr = m_rdy && (free > 0);
    exp_lr = m_rdy && (free >= 2 || (free == 1 && !sv));
    chk("fifo_count", 32'(fifo_count), q.size());
    chk("req_valid", 32'(req_valid), 32'(q.size() != 0));
    chk("shared_ready", 32'(shared_ready), 32'(exp_sr));
    chk("l1_ready", 32'(l1_ready), 32'(exp_lr));
    chk("illegal_op", 32'(illegal_op), 32'(m_ill));
    chk("err_count", 32'(err_count), m_err);
    if (q.size() != 0) begin
      chk("head_kind", 32'(req_kind), q[0].kind);
      chk("head_tag", 32'(req_tag), q[0].addr >> 20);
      chk("head_index", 32'(req_index), (q[0].addr >> 6) & 32'h3FFF);
      chk("head_offset", 32'(req_offset), q[0].addr & 32'h3F);
      chk("head_snoop", 32'(req_is_snoop), 32'(q[0].kind >= 2));
    end
    deq  = (q.size() != 0) && rr;
    nill = 0;
    if (deq) void'(q.pop_front());
    if (sv && exp_sr) begin
      k = kind_of(1'b1, sop);
      if (k < 0) nill++; else q.push_back('{kind: k, addr: sa});
    end
    if (lv && exp_lr) begin
      k = kind_of(1'b0, lop);
      if (k < 0) nill++; else q.push_back('{kind: k, addr: la});
    end
    m_err = (m_err + nill > 255) ? 255 : m_err + nill;
    m_ill = (nill > 0);
    @(posedge clk);
    #1;
    m_rdy = 1;
  endtask

  task automatic idle(input bit rr);
    cycle(0, 8'h00, 32'h0, 0, 8'h00, 32'h0, rr);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    shared_valid = 1'b1; shared_op = 8'h52; shared_addr = $urandom;
    l1_valid = 1'b1; l1_op = 8'h57; l1_addr = $urandom;
    req_ready = 1'b0;
    #1;
    chk("rst_shared_ready", 32'(shared_ready), 0);
    chk("rst_l1_ready", 32'(l1_ready), 0);
    @(posedge clk);
    #1;
    chk("rst_shared_ready2", 32'(shared_ready), 0);
    chk("rst_l1_ready2", 32'(l1_ready), 0);
    chk("rst_count", 32'(fifo_count), 0);
    chk("rst_req_valid", 32'(req_valid), 0);
    chk("rst_err", 32'(err_count), 0);
    chk("rst_illegal", 32'(illegal_op), 0);
    q.delete();
    m_err = 0; m_ill = 0; m_rdy = 0;
    reset = 1'b0;
    shared_valid = 1'b0; l1_valid = 1'b0;
  endtask

  task automatic random_phase(input int n);
    for (int i = 0; i < n; i++)
      cycle(bit'($urandom_range(0, 1)), ops[$urandom_range(0, 4)], $urandom,
            bit'($urandom_range(0, 1)), ops[$urandom_range(0, 4)], $urandom,
            bit'($urandom_range(0, 1)));
  endtask

  initial begin
    @(posedge clk);
    do_reset();
    idle(0);
    idle(0);

    // Single L1 read into the empty FIFO, visible one cycle later.
    cycle(0, 8'h00, 32'h0, 1, 8'h52, 32'h1234_5678, 1);
    chk("v1_valid", 32'(req_valid), 1);
    chk("v1_kind", 32'(req_kind), 0);
    chk("v1_tag", 32'(req_tag), 32'h123);
    chk("v1_index", 32'(req_index), 32'h1159);
    chk("v1_offset", 32'(req_offset), 32'h38);
    idle(1);
    idle(0);

    // Three held, then snoop M and L1 W collide on the last slot.
    for (int i = 0; i < 3; i++) cycle(0, 8'h00, 32'h0, 1, 8'h52, $urandom, 0);
    cycle(1, 8'h4D, 32'hABCD_0040, 1, 8'h57, 32'h5555_1000, 0);
    chk("v2_full", 32'(fifo_count), 4);
    cycle(0, 8'h00, 32'h0, 1, 8'h57, 32'h5555_1000, 1);
    cycle(0, 8'h00, 32'h0, 1, 8'h57, 32'h5555_1000, 0);
    cycle(0, 8'h00, 32'h0, 0, 8'h00, 32'h0, 0);
    chk("v2_l1_taken", 32'(fifo_count), 4);

    // Full FIFO held with no consumer: readies low, head stable.
    for (int i = 0; i < 10; i++)
      cycle(1, 8'h52, $urandom, 1, 8'h52, $urandom, 0);
    for (int i = 0; i < 5; i++) idle(1);

    // Illegal opcodes: single, dual, then saturation.
    cycle(1, 8'h58, 32'h0, 0, 8'h00, 32'h0, 0);
    idle(0);
    chk("v4_err1", 32'(err_count), 1);
    cycle(1, 8'h58, 32'h0, 1, 8'h4D, 32'h0, 0);
    idle(0);
    chk("v4_err3", 32'(err_count), 3);
    for (int i = 0; i < 256; i++) cycle(1, 8'h58, 32'h0, 0, 8'h00, 32'h0, 0);
    idle(0);
    chk("v4_sat", 32'(err_count), 255);

    // Random mixed traffic across many pointer wraps.
    random_phase(400);
    for (int i = 0; i < 6; i++) idle(1);

    // Reset with three entries queued.
    for (int i = 0; i < 3; i++) cycle(1, 8'h49, $urandom, 0, 8'h00, 32'h0, 0);
    cycle(1, 8'h58, 32'h0, 0, 8'h00, 32'h0, 0);
    do_reset();
    idle(0);
    idle(0);
    random_phase(100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/l2_bus_receiver.md
L2_BUS_RECEIVER -- requirements
Module: l2_bus_receiver

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, address width on both buses.
REQ-002 Parameter OFFSET_BITS, default 6, line-offset field width (64 B lines).
REQ-003 Parameter INDEX_BITS, default 14, set-index field width; tag width = ADDR_WIDTH-INDEX_BITS-OFFSET_BITS.
REQ-004 Parameter DEPTH, default 4, request FIFO entries (power of two, >=2).
REQ-005 clk  in  1  sole clock; all state updates on rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 l1_addr  in  ADDR_WIDTH  L1-side request address.
REQ-008 l1_op  in  8  L1 opcode, ASCII: "R"=8'h52, "W"=8'h57.
REQ-009 l1_valid  in  1  L1 request present.
REQ-010 l1_ready  out  1  L1 request accepted this cycle when high with l1_valid.
REQ-011 shared_addr  in  ADDR_WIDTH  snooped-bus address.
REQ-012 shared_op  in  8  snoop opcode, ASCII: "I"=8'h49, "R"=8'h52, "W"=8'h57, "M"=8'h4D.
REQ-013 shared_valid  in  1  snoop request present.
REQ-014 shared_ready  out  1  snoop request accepted this cycle when high with shared_valid.
REQ-015 req_valid  out  1  head-of-FIFO request available to cache controller.
REQ-016 req_ready  in  1  cache controller consumes head when high with req_valid.
REQ-017 req_kind  out  3  0 L1_READ, 1 L1_WRITE, 2 SNP_INVAL, 3 SNP_READ, 4 SNP_WRITE, 5 SNP_RWIM.
REQ-018 req_tag / req_index / req_offset  out  tag/INDEX_BITS/OFFSET_BITS  decoded address fields, MSB to LSB.
REQ-019 req_is_snoop  out  1  high for kinds 2-5.
REQ-020 fifo_count  out  $clog2(DEPTH)+1  current occupancy.
REQ-021 illegal_op  out  1  one-cycle pulse when an unrecognised opcode is accepted.
REQ-022 err_count  out  8  saturating count of illegal opcodes.

Function
REQ-023 Accept readiness SHALL depend only on registered occupancy, never on same-cycle dequeue.
REQ-024 shared_ready SHALL be high when fifo_count < DEPTH.
REQ-025 l1_ready SHALL be high when free slots >= 2, or free slots == 1 and shared_valid low; snoop has priority.
REQ-026 Both requests accepted in one cycle SHALL enqueue snoop first, then L1 (two writes that edge).
REQ-027 Legal opcodes SHALL map per REQ-017; "R"/"W" on L1 side, "I"/"R"/"W"/"M" on snoop side only.
REQ-028 An accepted illegal opcode SHALL be consumed, not enqueued, pulse illegal_op next cycle, increment err_count saturating at 255.
REQ-029 Two illegal opcodes accepted in one cycle SHALL add 2 (saturating), single illegal_op pulse.
REQ-030 Enqueued entry SHALL appear at head no earlier than the cycle after acceptance (one-cycle latency into empty FIFO).
REQ-031 req_valid SHALL equal fifo_count != 0; head payload SHALL stay stable while req_valid && !req_ready.
REQ-032 Dequeue on req_valid && req_ready; simultaneous enqueue and dequeue SHALL update count by net change.
REQ-033 Read/write pointers SHALL wrap modulo DEPTH; ordering strictly FIFO.
REQ-034 Address fields SHALL be pure bit slices of the stored address, no arithmetic.

Reset
REQ-035 While reset is high at an edge: FIFO flushed, pointers 0, fifo_count 0, err_count 0, illegal_op 0.
REQ-036 During and the cycle after reset: req_valid 0, l1_ready 0, shared_ready 0; ready rises the following cycle.
REQ-037 Reset mid-transfer SHALL discard all queued entries; requests presented during reset are not accepted.

Verification
REQ-038 L1 "R" addr 32'h1234_5678 into empty FIFO, req_ready=1 -> next cycle req_valid=1, kind 0, tag 12'h123, index 14'h1159, offset 6'h38.
REQ-039 Snoop "M" and L1 "W" same cycle, 3 entries held -> snoop enqueued, l1_ready=0; L1 accepted the cycle after a dequeue.
REQ-040 Fill 4 entries with req_ready=0 -> fifo_count=4, both readies 0, head payload unchanged over 10 cycles.
REQ-041 Snoop op 8'h58 ("X") -> not enqueued, illegal_op pulse 1 cycle, err_count 1; 256 more -> err_count 255.
REQ-042 6 alternating requests with random req_ready -> output order equals acceptance order across pointer wrap.
REQ-043 Assert reset with 3 queued -> next cycle fifo_count 0, req_valid 0, err_count 0, readies 0 then 1.
